// File: rtl/gate_drv_pkg.sv
// gate_drv_pkg: shared types and width helpers for the bridge gate driver.
//   state_t  - gate driver FSM states
//   cnt_w()  - counter width able to hold values 0..max_val
//   *_DEF    - default timing parameters and their derived counter widths
package gate_drv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        DEAD  = 3'd2,
        DRIVE = 3'd3,
        FAULT = 3'd4
    } state_t;

    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    localparam int DEAD_TIME_DEF = 15;
    localparam int WATCHDOG_DEF  = 255;
    localparam int DEAD_W_DEF    = cnt_w(DEAD_TIME_DEF);
    localparam int WD_W_DEF      = cnt_w(WATCHDOG_DEF);

endpackage

// File: rtl/gate_drv_edge_det.sv
// edge_det: registers a single-bit signal and flags a change between the
// current input and its registered copy (combinational, same cycle).
//   clk, rst_n - clock, asynchronous active-low reset
//   sig        - input level
//   sig_q      - sig delayed by one clock (resets to 0)
//   chg        - sig ^ sig_q
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic sig_q,
    output logic chg
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= 1'b0;
        else        sig_q <= sig;
    end

    assign chg = sig ^ sig_q;

endmodule

// File: rtl/gate_drv.sv
// gate_drv: turns predicted feedback polarity into two complementary bridge
// gate commands with a fixed dead time, gated by the interrupter enable.
//   clk, rst_n     - clock, asynchronous active-low reset
//   sgn            - predicted feedback polarity
//   en             - interrupter enable
//   ocd            - overcurrent detect (highest priority)
//   fault_clr      - fault acknowledge (honoured only with en=0, ocd=0)
//   out_a, out_b   - gate commands, never both high
//   active         - state is DEAD or DRIVE
//   fault          - latched overcurrent flag
//   wd_trip        - one-cycle pulse when a burst is aborted for lost feedback
module gate_drv
    import gate_drv_pkg::*;
#(
    parameter int DEAD_TIME = DEAD_TIME_DEF,
    parameter int WATCHDOG  = WATCHDOG_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sgn,
    input  logic en,
    input  logic ocd,
    input  logic fault_clr,
    output logic out_a,
    output logic out_b,
    output logic active,
    output logic fault,
    output logic wd_trip
);

    localparam int DW = cnt_w(DEAD_TIME);
    localparam int WW = cnt_w(WATCHDOG);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_TIME - 1);
    localparam logic [WW-1:0] WD_LIM    = WW'(WATCHDOG - 1);
    localparam logic [WW-1:0] WD_MAX    = WW'(WATCHDOG);

    state_t        state, state_nxt;
    logic          tgt, tgt_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic [WW-1:0] wd, wd_nxt;
    logic          wd_clr;
    logic          out_a_nxt, out_b_nxt, fault_nxt, trip_nxt;
    logic          sgn_q, chg;

    edge_det u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (sgn),
        .sig_q (sgn_q),
        .chg   (chg)
    );

    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt;
        dcnt_nxt  = dcnt;
        out_a_nxt = 1'b0;
        out_b_nxt = 1'b0;
        fault_nxt = fault;
        trip_nxt  = 1'b0;
        wd_clr    = chg;
        if (ocd) begin
            state_nxt = FAULT;
            fault_nxt = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state_nxt = ARM;
                        wd_clr    = 1'b1;
                    end
                end
                ARM: begin
                    if (!en) begin
                        state_nxt = IDLE;
                    end else if (chg) begin
                        state_nxt = DEAD;
                        tgt_nxt   = sgn;
                        dcnt_nxt  = DEAD_LOAD;
                    end else if (wd >= WD_LIM) begin
                        // Kick: no feedback yet, so drive opposite to the
                        // current level. The kick restarts the watchdog so
                        // the kicked half-cycle gets a full window too.
                        state_nxt = DEAD;
                        tgt_nxt   = ~sgn_q;
                        dcnt_nxt  = DEAD_LOAD;
                        wd_clr    = 1'b1;
                    end
                end
                DEAD: begin
                    // en is ignored here: the half-cycle always completes and
                    // the burst ends at the next feedback edge in DRIVE.
                    if (chg) begin
                        tgt_nxt  = sgn;
                        dcnt_nxt = DEAD_LOAD;
                    end else if (dcnt == '0) begin
                        state_nxt = DRIVE;
                        out_a_nxt = tgt;
                        out_b_nxt = ~tgt;
                    end else begin
                        dcnt_nxt = dcnt - 1'b1;
                    end
                end
                DRIVE: begin
                    if (chg) begin
                        if (en) begin
                            state_nxt = DEAD;
                            tgt_nxt   = sgn;
                            dcnt_nxt  = DEAD_LOAD;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else if (wd >= WD_LIM) begin
                        state_nxt = IDLE;
                        trip_nxt  = 1'b1;
                    end else begin
                        out_a_nxt = out_a;
                        out_b_nxt = out_b;
                    end
                end
                FAULT: begin
                    if (fault_clr && !en) begin
                        state_nxt = IDLE;
                        fault_nxt = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Saturating watchdog: measures clocks since the last feedback edge.
    always_comb begin
        wd_nxt = wd;
        if (wd_clr)
            wd_nxt = '0;
        else if ((state inside {ARM, DEAD, DRIVE}) && (wd != WD_MAX))
            wd_nxt = wd + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tgt     <= 1'b0;
            dcnt    <= '0;
            wd      <= '0;
            out_a   <= 1'b0;
            out_b   <= 1'b0;
            active  <= 1'b0;
            fault   <= 1'b0;
            wd_trip <= 1'b0;
        end else begin
            state   <= state_nxt;
            tgt     <= tgt_nxt;
            dcnt    <= dcnt_nxt;
            wd      <= wd_nxt;
            out_a   <= out_a_nxt;
            out_b   <= out_b_nxt;
            active  <= (state_nxt == DEAD) || (state_nxt == DRIVE);
            fault   <= fault_nxt;
            wd_trip <= trip_nxt;
        end
    end

endmodule

// File: tb/tb_gate_drv.sv
// tb_gate_drv: scoreboard bench for gate_drv. Each stimulus step pushes the
// expected {out_a,out_b,active,fault,wd_trip} for a future cycle; a negedge
// monitor pops and compares when that cycle arrives. A random phase checks
// output exclusivity and minimum dead gap between polarity changes.
module tb_gate_drv;

    localparam int DT = 4;
    localparam int WD = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sgn = 1'b0;
    logic en = 1'b0;
    logic ocd = 1'b0;
    logic fault_clr = 1'b0;
    logic out_a, out_b, active, fault, wd_trip;
    logic [4:0] obs;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [4:0] v;
        string      tag;
    } sb_t;
    sb_t sb[$];

    bit         rnd_on = 1'b0;
    logic [1:0] prev_pat = 2'b00;
    logic [1:0] pat;
    int         zrun = 0;
    int         mi;
    logic       pol;

    gate_drv #(.DEAD_TIME(DT), .WATCHDOG(WD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sgn       (sgn),
        .en        (en),
        .ocd       (ocd),
        .fault_clr (fault_clr),
        .out_a     (out_a),
        .out_b     (out_b),
        .active    (active),
        .fault     (fault),
        .wd_trip   (wd_trip)
    );

    assign obs = {out_a, out_b, active, fault, wd_trip};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic exp_at(input int dc, input logic [4:0] v, input string tag);
        sb_t e;
        e.cyc = cyc + dc;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        mi = 0;
        while (mi < sb.size()) begin
            if (sb[mi].cyc == cyc) begin
                chk(sb[mi].tag, 32'(obs), 32'(sb[mi].v));
                sb.delete(mi);
            end else begin
                mi++;
            end
        end
    end

    // invariant monitor for the random phase
    always @(negedge clk) begin
        if (rnd_on) begin
            pat = {out_a, out_b};
            chk("excl", 32'(out_a & out_b), 32'd0);
            if (pat != 2'b00 && pat != prev_pat)
                chk("gap", 32'(zrun >= DT), 32'd1);
            zrun     = (pat == 2'b00) ? zrun + 1 : 0;
            prev_pat = pat;
        end
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(obs), 32'd0);
        tick(1);
        rst_n = 1'b1;
        exp_at(2, 5'b00000, "idle");
        tick(3);

        // normal burst: edges every 50 clks, en drops before the last edge
        en = 1'b1;
        exp_at(1, 5'b00000, "arm");
        tick(2);
        for (int i = 0; i < 7; i++) begin
            sgn = ~sgn;
            if (i < 6) begin
                exp_at(1,      5'b00100, "b_dead0");
                exp_at(DT,     5'b00100, "b_deadN");
                exp_at(DT + 1, {sgn, ~sgn, 3'b100}, "b_pol");
                exp_at(49,     {sgn, ~sgn, 3'b100}, "b_hold");
            end else begin
                exp_at(1,      5'b00000, "b_end");
                exp_at(DT + 1, 5'b00000, "b_stay");
            end
            if (i == 5) begin
                tick(20);
                en = 1'b0;
                tick(30);
            end else begin
                tick(50);
            end
        end

        // kick start: sgn held, en=1
        en = 1'b1;
        exp_at(WD,         5'b00000, "k_arm");
        exp_at(WD + 1,     5'b00100, "k_dead");
        exp_at(WD + DT,    5'b00100, "k_dead_end");
        exp_at(WD + DT + 1, {~sgn, sgn, 3'b100}, "k_pol");
        exp_at(2 * WD,     {~sgn, sgn, 3'b100}, "k_hold");
        exp_at(2 * WD + 1, 5'b00001, "k_trip");
        exp_at(2 * WD + 2, 5'b00000, "k_trip_1cyc");
        tick(2 * WD + 3);
        en = 1'b0;
        tick(5);

        // edge during DEAD restarts the dead counter; en drop in DEAD
        en = 1'b1;
        tick(2);
        sgn = ~sgn;
        exp_at(1,      5'b00100, "d_dead");
        exp_at(DT + 1, 5'b00100, "d_restart");
        tick(2);
        sgn = ~sgn;
        pol = sgn;
        exp_at(DT,     5'b00100, "d_dead_last");
        exp_at(DT + 1, {pol, ~pol, 3'b100}, "d_pol");
        tick(1);
        en = 1'b0;
        exp_at(15, {pol, ~pol, 3'b100}, "d_hold");
        tick(17);
        sgn = ~sgn;
        exp_at(1, 5'b00000, "d_end");
        tick(8);

        // overcurrent, coinciding with a feedback edge
        en = 1'b1;
        tick(2);
        sgn = ~sgn;
        exp_at(DT + 1, {sgn, ~sgn, 3'b100}, "o_drive");
        tick(8);
        ocd = 1'b1;
        sgn = ~sgn;
        exp_at(1, 5'b00010, "o_fault");
        tick(1);
        ocd = 1'b0;
        exp_at(1, 5'b00010, "o_latched");
        tick(1);
        fault_clr = 1'b1;
        exp_at(1, 5'b00010, "o_clr_en");
        tick(1);
        en  = 1'b0;
        ocd = 1'b1;
        exp_at(1, 5'b00010, "o_clr_ocd");
        tick(1);
        ocd = 1'b0;
        exp_at(1, 5'b00000, "o_clr");
        tick(1);
        fault_clr = 1'b0;
        exp_at(2, 5'b00000, "o_idle");
        tick(4);

        // asynchronous reset mid-DRIVE
        en = 1'b1;
        tick(2);
        sgn = ~sgn;
        exp_at(DT + 1, {sgn, ~sgn, 3'b100}, "r_drive");
        tick(10);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(obs), 32'd0);
        en = 1'b0;
        tick(2);
        rst_n = 1'b1;
        exp_at(3, 5'b00000, "r_idle");
        tick(2);
        sgn = ~sgn;
        exp_at(2, 5'b00000, "r_idle_edge");
        tick(4);
        en = 1'b1;
        exp_at(1, 5'b00000, "r_arm");
        tick(2);
        sgn = ~sgn;
        exp_at(DT + 1, {sgn, ~sgn, 3'b100}, "r_rearm");
        tick(8);
        en  = 1'b0;
        sgn = ~sgn;
        exp_at(1, 5'b00000, "r_end");
        tick(3);

        // random invariant phase
        en       = 1'b1;
        zrun     = 0;
        prev_pat = 2'b00;
        rnd_on   = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) sgn = ~sgn;
            if ($urandom_range(0, 99) == 0) en = ~en;
            ocd       = ($urandom_range(0, 499) == 0);
            fault_clr = ($urandom_range(0, 7) == 0);
            tick(1);
        end
        rnd_on    = 1'b0;
        ocd       = 1'b0;
        fault_clr = 1'b0;

        // drain scoreboard with a bound
        for (int w = 0; w < 200 && sb.size() > 0; w++) tick(1);
        if (sb.size() > 0) chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
